tdm_demux4: RTL
===============

# tdm_demux4

Four-channel time-division demultiplexer and deserializer. It receives a serial stream in which four channels are interleaved one bit per slot, with slots 0,1,2,3 repeating. It rebuilds one WIDTH-bit word per channel and presents all four words together with a one-cycle valid strobe. The block sits at the receiving end of the team's 4:1 channel-select path and includes frame-sync acquisition and loss-of-lock detection.

## Interface
- WIDTH, 8, bits per channel word; must be ≥2 and a power of two.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- en  input  1  sample qualifier; din and sync are ignored when en=0.
- din  input  1  serial TDM data bit for the current slot.
- sync  input  1  word-start marker; high with the first bit (slot 0, bit 0) of each word group.
- data_out  output  4*WIDTH  channel k word at data_out[k*WIDTH +: WIDTH].
- valid  output  1  one-cycle strobe; data_out holds a new word group.
- locked  output  1  high while the FSM is in LOCK.
- sync_err  output  1  one-cycle strobe on a sync violation.

## Operation
- Reset (rst_n=0 at a rising edge) clears all state:
  - data_out=0, valid=0, locked=0, sync_err=0.
  - Slot counter=0, bit counter=0, all four shift registers=0, FSM in HUNT.
- Reset takes priority over every other event, including in the middle of a word.
- State: slot counter (2 bits), bit counter (log2 WIDTH bits), four WIDTH-bit shift registers sr0..sr3, 2-state FSM.
- HUNT state:
  - din is discarded.
  - On en=1 and sync=1, this cycle is slot 0, bit 0: shift din into sr0, set slot=1, bit=0, go to LOCK.
- LOCK state, each cycle with en=1:
  - Expected position is slot 0 and bit 0, with sync=1 and en=1: normal. Shift din into sr[slot] (shift left, din enters the LSB, so channel data arrives MSB first), then advance the counters.
  - sync=1 at any other position: pulse sync_err and discard the partial group. Treat the cycle as slot 0, bit 0: clear sr1..sr3, load sr0 with {0..0, din}, set slot=1, bit=0. Stay in LOCK.
  - Expected position with sync=0: pulse sync_err, clear counters and shift registers, go to HUNT. din is not captured.
  - Counter advance: slot increments and wraps 3→0. On the wrap, bit increments and wraps WIDTH-1→0.
- Group completion: at the edge that captures slot 3, bit WIDTH-1, data_out is loaded with the four completed words (including that final bit) and valid=1 for that one cycle. The counters wrap to 0/0.
- en=0: all counters, shift registers and the FSM hold. valid and sync_err return to 0. data_out holds.
- data_out changes only on group completion or reset. It keeps its last value across HUNT and sync errors.
- locked = (FSM == LOCK), registered.

## Timing
- All outputs are registered and update only on the rising edge of clk. No combinational path from inputs to outputs.
- Latency: valid rises at the same edge that samples the last bit of the group. From the first bit of a group to valid is 4*WIDTH enabled cycles.
- Minimum spacing between valid pulses is 4*WIDTH cycles. There is no back-pressure; the consumer must take data_out while valid=1 or before the next group completes.
- valid and sync_err are single-cycle pulses and never both high in the same cycle.
- locked rises one edge after the acquiring sync sample is seen and falls at the edge that detects a missing sync.
- Throughput: one bit per enabled cycle. en may toggle arbitrarily; gaps in en do not affect alignment.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random din/sync/en → data_out=0, valid=0, locked=0, sync_err=0. Then drive a single mid-group rst_n=0 → all state cleared and the FSM back in HUNT.
- Basic frame, WIDTH=8: send sync, then channel words 0xA5, 0x3C, 0xFF, 0x01, interleaved MSB first over 32 enabled cycles.
  - Required: valid pulses once, exactly at the 32nd sample.
  - Required: data_out = 0x01FF3CA5, locked=1 from the edge after the first sample.
- Back-to-back groups with en deasserted at random cycles (about 30%): send a second group 0x11, 0x22, 0x33, 0x44 → the second valid gives data_out = 0x44332211, and no sync_err occurs.
- Early sync: assert sync at slot 2, bit 5 of a group.
  - Required: sync_err pulses, no valid for the partial group, and locked stays 1.
  - Required: the next 32 samples produce a correct group.
- Missing sync: after a good group, hold sync=0 at the next expected word start.
  - Required: sync_err pulses, locked=0, and data_out holds its previous value.
  - Required: no valid until a new sync, after which a group is decoded correctly.
- Sync while in HUNT with en=0 → ignored: locked stays 0, and the counters do not advance.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Serial TDM input and deserialized word-group outputs of tdm_demux4.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic               en;
    logic               din;
    logic               sync;
    logic [4*WIDTH-1:0] data_out;
    logic               valid;
    logic               locked;
    logic               sync_err;

    modport master (
        output en, din, sync,
        input  data_out, valid, locked, sync_err
    );

    modport slave (
        input  en, din, sync,
        output data_out, valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM deserializer with frame-sync acquisition and
// loss-of-lock detection.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         slot;
    logic [BW-1:0]      bitc;
    logic [WIDTH-1:0]   sr [4];
    logic [4*WIDTH-1:0] data_q;
    logic               valid_q;
    logic               err_q;
    logic               locked_c;

    logic pos0;
    logic last;
    logic acquire;
    logic resync;
    logic drop;
    logic shift;

    assign pos0 = (slot == 2'd0) && (bitc == '0);
    assign last = (slot == 2'd3) && (bitc == BW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acquire   = 1'b0;
        resync    = 1'b0;
        drop      = 1'b0;
        shift     = 1'b0;
        if (bus.en) begin
            unique case (state)
                HUNT: begin
                    if (bus.sync) begin
                        acquire   = 1'b1;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (pos0 && !bus.sync) begin
                        drop      = 1'b1;
                        state_nxt = HUNT;
                    end else if (!pos0 && bus.sync) begin
                        resync = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked_c = (state == LOCK);
    end

    // Acquire and resync both treat the current sample as slot 0, bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) sr[k] <= '0;
            slot    <= '0;
            bitc    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (acquire || resync) begin
                sr[0] <= WIDTH'(bus.din);
                sr[1] <= '0;
                sr[2] <= '0;
                sr[3] <= '0;
                slot  <= 2'd1;
                bitc  <= '0;
                err_q <= resync;
            end else if (drop) begin
                for (int k = 0; k < 4; k++) sr[k] <= '0;
                slot  <= '0;
                bitc  <= '0;
                err_q <= 1'b1;
            end else if (shift) begin
                sr[slot] <= {sr[slot][WIDTH-2:0], bus.din};
                slot     <= slot + 2'd1;
                if (slot == 2'd3) bitc <= bitc + 1'b1;
                if (last) begin
                    data_q  <= {sr[3][WIDTH-2:0], bus.din,
                                sr[2], sr[1], sr[0]};
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.sync_err = err_q;
    assign bus.locked   = locked_c;
endmodule
